// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// RV32M funct3 operation codes and the unit's FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring
// divide sharing one accumulator, one bit per cycle, valid/ready out.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);
  import mdu_pkg::*;

  localparam int CW = $clog2(XLEN);

  state_e state, state_nx;

  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  hi, lo, opnd;
  logic [XLEN-1:0]  hi_nx, lo_nx;
  op_e              op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q, neg_r;

  op_e             op_in;
  logic            accept, last;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, ovf, special;

  assign op_in  = op_e'(i_op);
  assign accept = i_valid && (state == S_IDLE) && !i_flush;
  assign last   = (cnt == CW'(XLEN - 1));

  assign sgn_a = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM})
                 && i_rs1_data[XLEN-1];
  assign sgn_b = (op_in inside {OP_MULH, OP_DIV, OP_REM})
                 && i_rs2_data[XLEN-1];
  assign abs_a = sgn_a ? -i_rs1_data : i_rs1_data;
  assign abs_b = sgn_b ? -i_rs2_data : i_rs2_data;

  assign div_zero = i_op[2] && (i_rs2_data == '0);
  assign ovf = (op_in inside {OP_DIV, OP_REM})
               && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (i_rs2_data == '1);
  assign special = div_zero || ovf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = special ? S_DONE : S_CALC;
      S_CALC: if (last) state_nx = S_DONE;
      S_DONE: if (i_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (i_flush) state_nx = S_IDLE;
  end

  // One iteration: multiply shifts right, divide shifts left.
  logic [XLEN:0] sum, shl, diff;

  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shl   = {hi, lo[XLEN-1]};
    diff  = shl - {1'b0, opnd};
    hi_nx = sum[XLEN:1];
    lo_nx = {sum[0], lo[XLEN-1:1]};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        hi_nx = diff[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = shl[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      op_q  <= OP_MUL;
      tag_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op_in;
      tag_q <= i_tag;
      neg_q <= special ? 1'b0 : (sgn_a ^ sgn_b);
      neg_r <= special ? 1'b0 : sgn_a;
      opnd  <= i_op[2] ? abs_b : abs_a;
      hi    <= '0;
      lo    <= i_op[2] ? abs_a : abs_b;
      // Special results land pre-formed: quotient in lo, rem in hi.
      if (div_zero) begin
        hi <= i_rs1_data;
        lo <= '1;
      end else if (ovf) begin
        lo <= i_rs1_data;
      end
    end else if (state == S_CALC && !i_flush) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;
  logic              sel_lo, sel_hi, sel_quo, sel_rem;

  assign prod = neg_q ? -{hi, lo} : {hi, lo};
  assign quo  = neg_q ? -lo : lo;
  assign rem  = neg_r ? -hi : hi;

  assign sel_lo  = (op_q == OP_MUL);
  assign sel_hi  = !op_q[2] && (op_q != OP_MUL);
  assign sel_quo = op_q[2] && !op_q[1];
  assign sel_rem = op_q[2] && op_q[1];

  always_comb begin
    res = '0;
    unique case (1'b1)
      sel_lo:  res = prod[XLEN-1:0];
      sel_hi:  res = prod[2*XLEN-1:XLEN];
      sel_quo: res = quo;
      sel_rem: res = rem;
      default: res = '0;
    endcase
  end

  assign o_valid  = (state == S_DONE);
  assign o_ready  = (state == S_IDLE);
  assign o_busy   = (state != S_IDLE);
  assign o_result = o_valid ? res : '0;
  assign o_tag    = o_valid ? tag_q : '0;

endmodule
